// File: rtl/packet_serializer.sv
// Packet serializer: pops one word from an upstream FIFO, appends an odd-parity
// bit, and shifts the word out LSB first framed by one start and one stop bit.
// Each serial bit is held for CLKS_PER_BIT clock cycles.
//
// FIFO handshake: the FIFO's "valid" is ~fifo_empty and our "ready" is
// tx_enable while idle. A pop happens only when both hold at a rising edge in
// IDLE; read_n is then low for exactly one cycle, and the popped word is
// expected on data_in during the following cycle, where it is captured.
module packet_serializer #(
  parameter int FIFO_WIDTH   = 63,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  fifo_empty,
  input  logic                  tx_enable,
  output logic                  read_n,
  output logic                  tx,
  output logic                  tx_busy,
  output logic [15:0]           packets_sent,
  output logic [2:0]            dbg_state
);

  // Shift register holds the data word plus the parity bit on top.
  localparam int BITS = FIFO_WIDTH + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(BITS);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BITS-1:0]   r_shift;
  logic [CW-1:0]     r_clk_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [15:0]       r_pkt_cnt;
  logic              r_tx;
  logic              w_tx_next;
  logic              w_tick_last;
  logic              w_in_frame;

  assign w_tick_last  = (r_clk_cnt == LAST_TICK);
  assign w_in_frame   = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign tx           = r_tx;
  assign packets_sent = r_pkt_cnt;
  assign dbg_state    = r_state;

  // Next-state, strobes, and the line value for the coming cycle.
  // tx is registered from the next state so the line lines up with the state.
  always_comb begin
    w_next    = r_state;
    w_tx_next = 1'b1;
    read_n    = 1'b1;
    tx_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        tx_busy = 1'b0;
        if (!fifo_empty && tx_enable) w_next = S_POP;
      end
      S_POP: begin
        read_n = 1'b0;
        w_next = S_WAIT;
      end
      S_WAIT:  w_next = S_START;
      S_START: if (w_tick_last) w_next = S_DATA;
      S_DATA:  if (w_tick_last && (r_bit_cnt == LAST_BIT)) w_next = S_STOP;
      S_STOP:  if (w_tick_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    case (w_next)
      S_START: w_tx_next = 1'b0;
      // At a bit boundary inside DATA the register shifts this same edge,
      // so the next bit is the one just above the current LSB.
      S_DATA:  w_tx_next = ((r_state == S_DATA) && w_tick_last) ? r_shift[1] : r_shift[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // State register and registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_next;
    end
  end

  // Bit-period counter: counts cycles within a bit, reloads at each boundary.
  always_ff @(posedge clk) begin
    if (reset || !w_in_frame || w_tick_last) r_clk_cnt <= '0;
    else                                      r_clk_cnt <= r_clk_cnt + CW'(1);
  end

  // Data bit index, advanced at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_DATA)) r_bit_cnt <= '0;
    else if (w_tick_last)             r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BW'(1);
  end

  // Capture word with odd parity on top; shift right after each data bit.
  always_ff @(posedge clk) begin
    if (reset)                                   r_shift <= '0;
    else if (r_state == S_WAIT)                  r_shift <= {~^data_in, data_in};
    else if ((r_state == S_DATA) && w_tick_last) r_shift <= {1'b0, r_shift[BITS-1:1]};
  end

  // Completed-packet counter, bumped on the last stop-bit cycle; wraps.
  always_ff @(posedge clk) begin
    if (reset)                                   r_pkt_cnt <= '0;
    else if ((r_state == S_STOP) && w_tick_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: two instances (4 and 1 clocks per bit) driven
// from tasks; expected line bits come from a frame model pushed into exp_q.
module tb_packet_serializer;

  localparam int C0 = 4;
  localparam int C1 = 1;
  localparam int PKT_GAP = 3 + 66 * C0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic [62:0] data_in = '0;
  logic        fe0 = 1'b1, en0 = 1'b0, fe1 = 1'b1, en1 = 1'b0;
  logic        rn0, tx0, busy0, rn1, tx1, busy1;
  logic [15:0] ps0, ps1;
  logic [2:0]  dbg0, dbg1;

  packet_serializer #(.FIFO_WIDTH(63), .CLKS_PER_BIT(C0)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .fifo_empty(fe0), .tx_enable(en0),
    .read_n(rn0), .tx(tx0), .tx_busy(busy0), .packets_sent(ps0), .dbg_state(dbg0)
  );

  packet_serializer #(.FIFO_WIDTH(63), .CLKS_PER_BIT(C1)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .fifo_empty(fe1), .tx_enable(en1),
    .read_n(rn1), .tx(tx1), .tx_busy(busy1), .packets_sent(ps1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] pkt_exp[2];
  logic cap[0:66*C0-1];

  typedef struct {
    logic [62:0] data;
    bit          sel;
    logic        par;
  } vec_t;
  vec_t vtab[7];

  function automatic logic f_tx(bit s);   return s ? tx1 : tx0;     endfunction
  function automatic logic f_rn(bit s);   return s ? rn1 : rn0;     endfunction
  function automatic logic f_busy(bit s); return s ? busy1 : busy0; endfunction
  function automatic logic [15:0] f_ps(bit s); return s ? ps1 : ps0; endfunction
  function automatic int f_c(bit s);      return s ? C1 : C0;       endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit s, input logic fe, input logic en);
    if (s) begin fe1 = fe; en1 = en; end
    else   begin fe0 = fe; en0 = en; end
  endtask

  // Frame model: start, 63 data bits LSB first, odd-parity bit, stop; each c cycles.
  task automatic build_exp(input int c, input logic [62:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    exp_q.delete();
    for (int k = 0; k < c; k++) exp_q.push_back(1'b0);
    for (int b = 0; b < 63; b++)
      for (int k = 0; k < c; k++) exp_q.push_back(d[b]);
    for (int k = 0; k < c; k++) exp_q.push_back(par);
    for (int k = 0; k < c; k++) exp_q.push_back(1'b1);
  endtask

  // Waits (bounded) for a read_n pulse, sampled at negedge.
  task automatic wait_pop(input bit s, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (f_rn(s) === 1'b0) ok = 1'b1;
    end
    check({name, "_pop_seen"}, ok, 1'b1);
  endtask

  // Called at the negedge where the pop was seen; follows the whole frame.
  task automatic check_frame(input bit s, input logic [62:0] d, input bit par_known,
                             input logic par, input bit drop_en, input string name);
    int c, errs, pops, busy_bad;
    logic [0:0] e;
    c = f_c(s);
    errs = 0; pops = 0; busy_bad = 0;
    if (!drop_en) set_in(s, 1'b1, 1'b1);
    build_exp(c, d);
    @(negedge clk);
    check({name, "_wait_tx"}, {f_tx(s), f_busy(s), f_rn(s)}, 3'b111);
    for (int i = 0; i < 66 * c; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      cap[i] = f_tx(s);
      if (f_tx(s) !== e[0]) errs++;
      if (f_rn(s) !== 1'b1) pops++;
      if (f_busy(s) !== 1'b1) busy_bad++;
      if (drop_en && i == 0) set_in(s, 1'b0, 1'b0);
    end
    pkt_exp[s] = pkt_exp[s] + 16'd1;
    check({name, "_frame_bits"}, errs, 0);
    check({name, "_extra_pop"}, pops, 0);
    check({name, "_busy"}, busy_bad, 0);
    if (par_known) check({name, "_parity"}, cap[64 * c], par);
    @(negedge clk);
    check({name, "_idle_after"}, {f_tx(s), f_busy(s)}, 2'b10);
    check({name, "_pkts"}, f_ps(s), pkt_exp[s]);
  endtask

  task automatic send(input bit s, input logic [62:0] d, input bit par_known,
                      input logic par, input string name);
    bit ok;
    data_in = d;
    set_in(s, 1'b0, 1'b1);
    wait_pop(s, name, ok);
    if (ok) check_frame(s, d, par_known, par, 1'b0, name);
    else    set_in(s, 1'b1, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int bad, pops;
    int pop_cyc[3];
    logic [62:0] d;

    vtab[0] = '{63'h0,                  1'b0, 1'b1};
    vtab[1] = '{63'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vtab[2] = '{63'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vtab[3] = '{63'h1,                  1'b0, 1'b0};
    vtab[4] = '{63'h3,                  1'b1, 1'b1};
    vtab[5] = '{63'h4000_0000_0000_0000, 1'b0, 1'b0};
    vtab[6] = '{63'h0000_0000_FFFF_FFFF, 1'b0, 1'b1};
    pkt_exp[0] = '0;
    pkt_exp[1] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_dut0", {tx0, rn0, busy0, ps0}, {3'b110, 16'h0});
    check("reset_dut1", {tx1, rn1, busy1, ps1}, {3'b110, 16'h0});
    reset = 1'b0;

    // Empty FIFO with enable high: nothing happens for 100 cycles.
    en0 = 1'b1; fe0 = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || rn0 !== 1'b1 || busy0 !== 1'b0 || ps0 !== 16'h0) bad++;
    end
    check("idle_empty_100", bad, 0);

    // Table-driven packets with hand-computed parity.
    for (int v = 0; v < 7; v++)
      send(vtab[v].sel, vtab[v].data, 1'b1, vtab[v].par, $sformatf("vec%0d", v));

    // Randomized packets against the frame model.
    for (int r = 0; r < 6; r++) begin
      d = {$urandom, $urandom};
      send(bit'($urandom_range(0, 1)), d, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    // Three words back to back: pops exactly one packet period apart.
    pops = 0;
    data_in = {$urandom, $urandom};
    fe0 = 1'b0; en0 = 1'b1;
    for (int i = 0; i < 3 * PKT_GAP + 40; i++) begin
      @(negedge clk);
      if (rn0 === 1'b0) begin
        if (pops < 3) pop_cyc[pops] = cyc;
        pops++;
        data_in = {$urandom, $urandom};
        if (pops == 3) fe0 = 1'b1;
      end
    end
    pkt_exp[0] = pkt_exp[0] + 16'd3;
    check("b2b_pop_count", pops, 3);
    if (pops >= 3) begin
      check("b2b_gap01", pop_cyc[1] - pop_cyc[0], PKT_GAP);
      check("b2b_gap12", pop_cyc[2] - pop_cyc[1], PKT_GAP);
    end
    check("b2b_pkts", ps0, pkt_exp[0]);
    check("b2b_idle", {busy0, tx0}, 2'b01);

    // Reset at the first cycle of data bit 10 of an all-zero word.
    data_in = '0;
    fe0 = 1'b0; en0 = 1'b1;
    wait_pop(1'b0, "rst_mid", ok);
    fe0 = 1'b1;
    if (ok) begin
      repeat (2 + 11 * C0) @(negedge clk);
      check("rst_mid_tx_before", tx0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_after", {tx0, busy0, rn0, ps0}, {3'b101, 16'h0});
      reset = 1'b0;
      pkt_exp[0] = '0;
      pkt_exp[1] = '0;
      bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (tx0 !== 1'b1 || rn0 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      check("rst_mid_quiet", bad, 0);
      check("rst_mid_pkts", ps0, 16'h0);
      send(1'b0, {$urandom, $urandom}, 1'b0, 1'b0, "post_rst");
    end

    // tx_enable dropped in START: packet completes, no pop until re-enabled.
    d = {$urandom, $urandom};
    data_in = d;
    fe0 = 1'b0; en0 = 1'b1;
    wait_pop(1'b0, "drop_en", ok);
    if (ok) begin
      check_frame(1'b0, d, 1'b0, 1'b0, 1'b1, "drop_en");
      pops = 0;
      repeat (50) begin
        @(negedge clk);
        if (rn0 === 1'b0) pops++;
      end
      check("drop_en_no_pop", pops, 0);
      d = {$urandom, $urandom};
      en0 = 1'b1;
      wait_pop(1'b0, "reenable", ok);
      data_in = d;
      if (ok) check_frame(1'b0, d, 1'b0, 1'b0, 1'b0, "reenable");
    end
    fe0 = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the sequence above is a few thousand cycles.
  initial begin
    #1000000;
    $display("FAIL watchdog: sequence did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
